// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 2:1 mux arbiter: FSM state encoding and the default hold limit.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    localparam int HOLD_MAX_DEFAULT = 8;

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Saturating hold counter: counts cycles an owner has held the grant, flags when HOLD_MAX-1 is reached.
module mux_arb_hold_cnt
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              CNT_W    = $clog2(HOLD_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Stops at CNT_LAST so a long uncontested hold never wraps back to a fresh count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mux_21_arbiter.sv
// Round-robin arbiter driving the select of a downstream 2:1 mux.
// Define MUX_ARB_TIMEOUT_EN to force an owner hand-off after HOLD_MAX cycles when the other source waits.
module mux_21_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] REQ,
    input  logic       DONE,
    output logic       S,
    output logic [1:0] GNT,
    output logic       BUSY
);

    state_e state_q, state_d;
    logic   s_q, s_d;
    logic   last_q, last_d;
    logic   hold_expired;

`ifdef MUX_ARB_TIMEOUT_EN
    logic hold_clr;
    logic hold_en;

    assign hold_clr = (state_d != IDLE) && (state_d != state_q);
    assign hold_en  = (state_q != IDLE);

    mux_arb_hold_cnt #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (hold_clr),
        .en      (hold_en),
        .expired (hold_expired)
    );
`else
    assign hold_expired = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                if (REQ == 2'b01) begin
                    state_d = OWN0;
                end else if (REQ == 2'b10) begin
                    state_d = OWN1;
                end else if (REQ == 2'b11) begin
                    state_d = last_q ? OWN0 : OWN1;
                end
            end
            OWN0: begin
                if (DONE || !REQ[0] || (hold_expired && REQ[1])) begin
                    state_d = REQ[1] ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (DONE || !REQ[1] || (hold_expired && REQ[0])) begin
                    state_d = REQ[0] ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Select and last-served pointer follow the owner; IDLE keeps the previous select.
        if (state_d == OWN0) begin
            s_d    = 1'b0;
            last_d = 1'b0;
        end else if (state_d == OWN1) begin
            s_d    = 1'b1;
            last_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
        end
    end

    assign GNT  = {state_q == OWN1, state_q == OWN0};
    assign BUSY = (state_q != IDLE);
    assign S    = s_q;

endmodule

// File: tb/tb_mux_21_arbiter.sv
// Directed table-driven bench for mux_21_arbiter plus a hand-written hold/timeout sequence.
`timescale 1ns/1ps
module tb_mux_21_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] REQ;
    logic       DONE;
    logic       S;
    logic [1:0] GNT;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    mux_21_arbiter #(
        .HOLD_MAX (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .REQ  (REQ),
        .DONE (DONE),
        .S    (S),
        .GNT  (GNT),
        .BUSY (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       done;
        logic [1:0] gnt;
        logic       s;
        logic       busy;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got GNT,S,BUSY=%b need %b", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic drive(input logic r, input logic [1:0] q, input logic d);
        @(negedge clk);
        rst  = r;
        REQ  = q;
        DONE = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        REQ  = 2'b00;
        DONE = 1'b0;

        //           rst   req    done  gnt    s     busy
        vecs[0]  = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0}; // reset held, requests ignored
        vecs[1]  = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 1'b1}; // first tie goes to source 0
        vecs[3]  = '{1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1}; // round robin, no idle gap
        vecs[4]  = '{1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 1'b1}; // no release, hold
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1}; // direct handoff on req drop
        vecs[9]  = '{1'b0, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0}; // done with only own req -> idle
        vecs[10] = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1}; // re-grant after one idle cycle
        vecs[11] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0}; // release, S holds 1
        vecs[12] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0}; // done in idle ignored
        vecs[13] = '{1'b0, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1}; // done in idle does not block grant
        vecs[14] = '{1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1, 1'b1}; // tie after source 0 -> source 1
        vecs[16] = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0}; // mid-grant reset
        vecs[17] = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 1'b1}; // reset restores last=1
        vecs[18] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0}; // owner drops req, nobody waiting
        vecs[19] = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1}; // owner drops, other takes over

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].done);
            check($sformatf("vec%0d", i), {GNT, S, BUSY},
                  {vecs[i].gnt, vecs[i].s, vecs[i].busy});
            if (GNT == 2'b11) begin
                check($sformatf("onehot%0d", i), {GNT, S, BUSY}, {2'b00, S, BUSY});
            end
        end

        // Contested hold: both request, nobody releases.
        drive(1'b1, 2'b11, 1'b0);
        drive(1'b0, 2'b11, 1'b0);
        check("hold_entry", {GNT, S, BUSY}, {2'b01, 1'b0, 1'b1});
        for (int i = 1; i <= 20; i++) begin
            logic [1:0] exp_gnt;
            drive(1'b0, 2'b11, 1'b0);
`ifdef MUX_ARB_TIMEOUT_EN
            exp_gnt = (((i / 4) % 2) == 1) ? 2'b10 : 2'b01;
`else
            exp_gnt = 2'b01;
`endif
            check($sformatf("hold%0d", i), {GNT, S, BUSY}, {exp_gnt, exp_gnt[1], 1'b1});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
